// File: rtl/mul_seq_if.sv
// ---------------------------------------------------------------------------
// mul_seq_if
//   Port group between the sequential multiplier, its requester and the
//   external adder32 it borrows.
//
//   Requester side : start_in, flush_in, a_in, b_in -> busy, done, product
//   Adder side     : add_a, add_b, add_cin -> adder32; add_sum, add_cout back
//
//   slave  : seen from mul_seq
//   master : seen from the requester / adder owner
// ---------------------------------------------------------------------------
interface mul_seq_if;
    logic        start_in;
    logic        flush_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    modport slave (
        input  start_in, flush_in, a_in, b_in, add_sum, add_cout,
        output busy, done, product, add_a, add_b, add_cin
    );

    modport master (
        output start_in, flush_in, a_in, b_in, add_sum, add_cout,
        input  busy, done, product, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq
//   32x32 unsigned shift-add multiplier controller. Owns no adder: it drives
//   an external combinational adder32 through the bus port group for 32
//   iterations and assembles a 64-bit product.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_seq_if.slave
//           start_in/a_in/b_in  request, sampled only in IDLE
//           flush_in            abort while in RUN
//           busy                high in RUN and DONE
//           done                one-cycle completion pulse
//           product             result register, holds until next completion
//           add_a/add_b/add_cin adder operands (zero outside RUN, cin = 0)
//           add_sum/add_cout    adder result, only looked at in RUN
//
//   BYPASS_ZERO : a zero operand at start skips RUN and completes with 0.
// ---------------------------------------------------------------------------
module mul_seq #(
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  count;
    logic [63:0] product_q;

    logic        zero_hit;
    logic        last_iter;

    assign zero_hit  = BYPASS_ZERO && ((bus.a_in == 32'd0) || (bus.b_in == 32'd0));
    assign last_iter = (count == 5'd31);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.add_a   = 32'd0;
        bus.add_b   = 32'd0;
        bus.add_cin = 1'b0;
        case (state)
            IDLE: begin
                // flush_in has no meaning here, so a simultaneous start wins
                if (bus.start_in) state_n = zero_hit ? DONE : RUN;
            end
            RUN: begin
                bus.busy  = 1'b1;
                bus.add_a = hi;
                // lo[0] is the multiplier bit for this iteration
                bus.add_b = lo[0] ? mcand : 32'd0;
                if (bus.flush_in)   state_n = IDLE;
                else if (last_iter) state_n = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath. {hi,lo} is the running partial product; each iteration adds
    // the (gated) multiplicand into hi and shifts the pair right by one, with
    // the adder carry landing in hi[31] so nothing is lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            count     <= 5'd0;
            product_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        mcand <= bus.a_in;
                        hi    <= 32'd0;
                        lo    <= bus.b_in;
                        count <= 5'd0;
                        if (zero_hit) product_q <= 64'd0;
                    end
                end
                RUN: begin
                    // A flushed iteration is dropped; the registers are
                    // reloaded on the next accepted start anyway.
                    if (!bus.flush_in) begin
                        hi    <= {bus.add_cout, bus.add_sum[31:1]};
                        lo    <= {bus.add_sum[0], lo[31:1]};
                        count <= count + 5'd1;
                        // Final iteration: take the shifted result straight
                        // from the adder instead of waiting for hi/lo.
                        if (last_iter)
                            product_q <= {bus.add_cout, bus.add_sum, lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    logic clk;
    logic rst_n;
    logic sel;            // 0: BYPASS_ZERO=1 instance, 1: BYPASS_ZERO=0 instance
    logic start;
    logic flush;
    logic [31:0] a_r;
    logic [31:0] b_r;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    mul_seq_if m1 ();
    mul_seq_if m0 ();

    mul_seq #(.BYPASS_ZERO(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m1));
    mul_seq #(.BYPASS_ZERO(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));

    // requester drive, steered to one instance at a time
    assign m1.start_in = start && !sel;
    assign m1.flush_in = flush && !sel;
    assign m1.a_in     = a_r;
    assign m1.b_in     = b_r;
    assign m0.start_in = start && sel;
    assign m0.flush_in = flush && sel;
    assign m0.a_in     = a_r;
    assign m0.b_in     = b_r;

    // adder32 models
    assign {m1.add_cout, m1.add_sum} = {1'b0, m1.add_a} + {1'b0, m1.add_b} + {32'd0, m1.add_cin};
    assign {m0.add_cout, m0.add_sum} = {1'b0, m0.add_a} + {1'b0, m0.add_b} + {32'd0, m0.add_cin};

    logic        busy_o, done_o, cin_o;
    logic [63:0] prod_o;
    logic [31:0] adda_o, addb_o;
    assign busy_o = sel ? m0.busy    : m1.busy;
    assign done_o = sel ? m0.done    : m1.done;
    assign prod_o = sel ? m0.product : m1.product;
    assign adda_o = sel ? m0.add_a   : m1.add_a;
    assign addb_o = sel ? m0.add_b   : m1.add_b;
    assign cin_o  = sel ? m0.add_cin : m1.add_cin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a request for one cycle; push the model result when the op is
    // expected to complete.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        @(posedge clk); #1;
        start = 1'b1; a_r = a; b_r = b;
        if (push) sb.push_back({32'd0, a} * {32'd0, b});
        @(negedge clk);
        check("idle_busy", {63'd0, busy_o}, 64'd0);
        check("idle_done", {63'd0, done_o}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called right after the accept edge; counts cycles until done, checking
    // the adder drive of each RUN iteration when asked.
    task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input int exp_lat, input bit chk_add);
        int  cyc  = 0;
        bit  seen = 1'b0;
        logic [63:0] exp;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_o) seen = 1'b1;
            else if (chk_add && cyc <= 32) begin
                check({tag, "_addb"}, {32'd0, addb_o}, {32'd0, (b[cyc-1] ? a : 32'd0)});
                check({tag, "_cin"},  {63'd0, cin_o}, 64'd0);
                check({tag, "_busy"}, {63'd0, busy_o}, 64'd1);
            end
        end
        check({tag, "_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_dbusy"}, {63'd0, busy_o}, 64'd1);
        if (sb.size() == 0) exp = 64'hDEAD_DEAD_DEAD_DEAD;
        else                exp = sb.pop_front();
        check({tag, "_prod"}, prod_o, exp);
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; flush = 1'b0; a_r = '0; b_r = '0;
        rst_n = 1'b0;
        #12;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_prod", prod_o, 64'd0);
        check("rst_adda", {32'd0, adda_o}, 64'd0);
        check("rst_addb", {32'd0, addb_o}, 64'd0);
        check("rst_prod0", m0.product, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // basic
        start_op(32'd7, 32'd6, 1'b1);
        wait_done("basic", 32'd7, 32'd6, 33, 1'b1);
        check("basic_const", prod_o, 64'd42);
        @(negedge clk);
        check("basic_pulse", {63'd0, done_o}, 64'd0);
        check("basic_idle", {63'd0, busy_o}, 64'd0);

        // maximum operands, carry every iteration
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
        check("max_const", prod_o, 64'hFFFF_FFFE_0000_0001);

        // zero bypass clears the previous product
        start_op(32'd0, 32'h1234, 1'b1);
        wait_done("byp_a0", 32'd0, 32'h1234, 1, 1'b0);
        start_op(32'h1234, 32'd0, 1'b1);
        wait_done("byp_b0", 32'h1234, 32'd0, 1, 1'b0);

        // no bypass: full-length run for a zero operand
        sel = 1'b1;
        start_op(32'd0, 32'h1234, 1'b1);
        wait_done("nobyp", 32'd0, 32'h1234, 33, 1'b1);
        sel = 1'b0;

        // busy / flush
        start_op(32'd11, 32'd13, 1'b1);
        wait_done("pre", 32'd11, 32'd13, 33, 1'b0);
        start_op(32'd3, 32'd5, 1'b0);
        repeat (8) @(posedge clk);
        #1 start = 1'b1; a_r = 32'd9; b_r = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("ign_busy", {63'd0, busy_o}, 64'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("fl_busy_pre", {63'd0, busy_o}, 64'd1);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("fl_busy", {63'd0, busy_o}, 64'd0);
        check("fl_done", {63'd0, done_o}, 64'd0);
        check("fl_prod", prod_o, 64'd143);
        repeat (40) begin
            @(negedge clk);
            if (done_o) check("fl_nodone", {63'd0, done_o}, 64'd0);
        end
        start_op(32'd3, 32'd5, 1'b1);
        wait_done("after_fl", 32'd3, 32'd5, 33, 1'b0);

        // back-to-back
        start_op(32'd2, 32'd3, 1'b1);
        wait_done("b2b_1", 32'd2, 32'd3, 33, 1'b0);
        start_op(32'd10, 32'd10, 1'b1);
        wait_done("b2b_2", 32'd10, 32'd10, 33, 1'b0);

        // asynchronous reset mid-RUN
        start_op(32'd5, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        check("prerst_busy", {63'd0, busy_o}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy_o}, 64'd0);
        check("arst_done", {63'd0, done_o}, 64'd0);
        check("arst_prod", prod_o, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stay", {63'd0, busy_o}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential 32x32 unsigned shift-add multiplier controller.
- Owns no adder: drives one external adder32 instance through a dedicated port group and sequences it over 32 iterations to build a 64-bit product.
- Sits beside the execute stage as the multi-cycle multiply unit. The adder can be shared with other logic whenever busy is low.

Parameters:
- BYPASS_ZERO, 1: when 1, an operand equal to zero at start skips RUN and goes straight to DONE with product 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_in  input  1  request to multiply; sampled only in IDLE
- flush_in  input  1  synchronous abort of an operation in progress
- a_in  input  32  multiplicand, captured when start is accepted
- b_in  input  32  multiplier, captured when start is accepted
- busy  output  1  high in RUN and DONE; start_in is ignored while high
- done  output  1  one-cycle pulse; product is valid from this cycle on
- product  output  64  result register
- add_a  output  32  to adder32 a_in
- add_b  output  32  to adder32 b_in
- add_cin  output  1  to adder32 carry_in; always 0
- add_sum  input  32  from adder32 sum
- add_cout  input  1  from adder32 carry_out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal hi/lo/mcand/count=0.
- Reset asserted mid-operation: immediate return to IDLE with all of the above. No done pulse.
- States: IDLE, RUN, DONE. Registers: mcand[31:0], hi[31:0], lo[31:0], count[4:0].
- IDLE:
  - Adder drive is add_a=0, add_b=0.
  - On start_in=1: mcand<=a_in, hi<=0, lo<=b_in, count<=0, then go to RUN.
  - Exception: if BYPASS_ZERO=1 and (a_in==0 or b_in==0), set product<=0 and go directly to DONE.
- RUN, each cycle:
  - Drive add_a=hi, add_b=lo[0] ? mcand : 0, add_cin=0.
  - Update hi<={add_cout, add_sum[31:1]}, lo<={add_sum[0], lo[31:1]}, count<=count+1.
  - When count==31: product<={add_cout, add_sum, lo[31:1]}, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. Adder drive is zero.
- Latency: the start-accept edge is edge 0. Iterations occur on edges 1..32. done is high in the cycle following edge 32, i.e. 33 cycles of busy in total.
- BYPASS_ZERO path: done is high in the cycle following edge 0.
- Back-to-back: the earliest next start is accepted in the cycle after DONE, when busy is low.
- product holds its value until the next completed operation. It is cleared only by reset or on BYPASS_ZERO completion.
- flush_in=1 in RUN: go to IDLE on the next edge. product is unchanged and no done pulse is issued. flush_in is ignored in IDLE and DONE.
- flush_in and start_in both high in IDLE: start wins, because flush has no effect in IDLE.
- Arithmetic and width rules:
  - Unsigned only. The 64-bit product is exact; no overflow is possible.
  - The adder carry is absorbed into hi[31] each iteration.
  - add_cin is tied 0.
- The controller makes no assumption about adder latency beyond purely combinational behaviour within one cycle.
- Adder outputs are ignored outside RUN.

Test Plan:
- Basic: rst_n pulse, then start with a=7, b=6 -> busy high 33 cycles, done pulse at edge-32 cycle, product=64'd42. Check add_b toggles 0/7 following the multiplier bits.
- Maximum: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001. Checks carry capture from add_cout on every iteration.
- Zero bypass, BYPASS_ZERO=1: a=0, b=32'h1234 -> done in the cycle after accept, product=0, busy high 1 cycle.
  - Repeat with BYPASS_ZERO=0 -> 33-cycle latency, product=0.
- Busy/flush:
  - Start a=3, b=5.
  - Pulse start_in with a=9, b=9 at cycle 10 -> ignored.
  - Assert flush_in at cycle 12 -> IDLE, no done, product keeps the prior value.
  - Then start a=3, b=5 -> product=15.
- Back-to-back and reset:
  - Start a=2, b=3 -> product=6.
  - Start in the first idle cycle after done with a=10, b=10 -> product=100.
  - Assert rst_n=0 asynchronously mid-RUN -> busy=0, done=0, product=0 immediately, no clock needed.
